// File: rtl/pipes.sv
// Shared types for the core pipeline: sequencing-controller state and the
// per-register enable/clear bundle driven to every *_reg instance.
package pipes;

    localparam int unsigned STALL_CNT_W = 32;

    typedef enum logic {CTRL_RUN, CTRL_DROP} ctrl_state_t;

    typedef struct packed {
        logic enF;
        logic enD;
        logic enE;
        logic enM;
        logic enW;
        logic clrD;
        logic clrE;
        logic clrM;
        logic clrW;
    } pipe_ctl_t;

    localparam pipe_ctl_t CTL_FLOW = '{enF: 1'b1, enD: 1'b1, enE: 1'b1, enM: 1'b1, enW: 1'b1,
                                       clrD: 1'b0, clrE: 1'b0, clrM: 1'b0, clrW: 1'b0};
    localparam pipe_ctl_t CTL_RESET = '{enF: 1'b1, enD: 1'b1, enE: 1'b1, enM: 1'b1, enW: 1'b1,
                                        clrD: 1'b1, clrE: 1'b1, clrM: 1'b1, clrW: 1'b1};
    localparam pipe_ctl_t CTL_HOLD = '{enF: 1'b0, enD: 1'b0, enE: 1'b0, enM: 1'b0, enW: 1'b0,
                                       clrD: 1'b0, clrE: 1'b0, clrM: 1'b0, clrW: 1'b0};

endpackage

// File: rtl/sat_counter.sv
// 32-bit counter that increments on inc and sticks at all-ones; sync reset
// loads RST_VAL.
module sat_counter #(
    parameter logic [31:0] RST_VAL = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    output logic [31:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= RST_VAL;
        end else if (inc && (count != 32'hFFFF_FFFF)) begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: resolves stall/redirect priority into
// enable/clear pairs for the pipeline registers and tracks stale fetches.
module pipe_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        ibus_busy,
    input  logic        ibus_done,
    input  logic        dbus_busy,
    input  logic        mdu_busy,
    input  logic        load_use,
    input  logic        redirect,
    output logic        en_f,
    output logic        en_d,
    output logic        en_e,
    output logic        en_m,
    output logic        en_w,
    output logic        clr_d,
    output logic        clr_e,
    output logic        clr_m,
    output logic        clr_w,
    output logic        redirect_go,
    output logic        fetch_drop,
    output logic [31:0] stall_cycles
);
    import pipes::*;

    ctrl_state_t state;
    ctrl_state_t stateNext;
    logic        pend;
    logic        pendNext;
    pipe_ctl_t   ctl;
    logic        redirectGo;
    logic        fetchDrop;
    logic        memStall;
    logic        exeStall;
    logic        fetchStall;
    logic        redirAct;

    assign memStall   = dbus_busy;
    assign exeStall   = mdu_busy;
    assign fetchStall = ibus_busy & ~ibus_done;
    // A redirect (live or deferred) can only steer the PC once the back end moves.
    assign redirAct   = (redirect | pend) & ~memStall & ~exeStall;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CTRL_RUN;
            pend  <= 1'b0;
        end else begin
            state <= stateNext;
            pend  <= pendNext;
        end
    end

    always_comb begin
        stateNext = state;
        pendNext  = pend;
        if (redirAct) begin
            pendNext = 1'b0;
        end else if (redirect) begin
            pendNext = 1'b1;
        end
        case (state)
            CTRL_RUN:  if (redirAct && fetchStall) stateNext = CTRL_DROP;
            CTRL_DROP: if (!redirAct && ibus_done) stateNext = CTRL_RUN;
        endcase
    end

    always_comb begin
        ctl        = CTL_FLOW;
        redirectGo = 1'b0;
        fetchDrop  = 1'b0;
        if (rst) begin
            ctl = CTL_RESET;
        end else begin
            fetchDrop = (state == CTRL_DROP) & ibus_done;
            if (memStall) begin
                ctl = CTL_HOLD;
            end else if (exeStall) begin
                ctl.enF  = 1'b0;
                ctl.enD  = 1'b0;
                ctl.enE  = 1'b0;
                ctl.clrM = 1'b1;
            end else if (redirAct) begin
                // Squashes IF/ID and ID/EX, so any load_use bubble is moot.
                redirectGo = 1'b1;
                ctl.clrD   = 1'b1;
                ctl.clrE   = 1'b1;
            end else if (load_use) begin
                ctl.enF  = 1'b0;
                ctl.enD  = 1'b0;
                ctl.clrE = 1'b1;
            end else if (fetchStall || (state == CTRL_DROP)) begin
                ctl.enF  = 1'b0;
                ctl.clrD = 1'b1;
            end
        end
    end

    assign en_f        = ctl.enF;
    assign en_d        = ctl.enD;
    assign en_e        = ctl.enE;
    assign en_m        = ctl.enM;
    assign en_w        = ctl.enW;
    assign clr_d       = ctl.clrD;
    assign clr_e       = ctl.clrE;
    assign clr_m       = ctl.clrM;
    assign clr_w       = ctl.clrW;
    assign redirect_go = redirectGo;
    assign fetch_drop  = fetchDrop;

    sat_counter uStallCnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (~ctl.enF & ~rst),
        .count (stall_cycles)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: stage-index reference model checked every cycle,
// directed scenarios with literal expectations, then random traffic.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ibus_busy, ibus_done, dbus_busy, mdu_busy, load_use, redirect;
    logic        en_f, en_d, en_e, en_m, en_w;
    logic        clr_d, clr_e, clr_m, clr_w;
    logic        redirect_go, fetch_drop;
    logic [31:0] stall_cycles;

    logic        satRst, satInc;
    logic [31:0] satCount;

    int checks = 0;
    int errors = 0;
    bit checkEn = 1'b0;

    logic        mPend = 1'b0;
    logic        mDrop = 1'b0;
    logic [31:0] mCnt  = 32'd0;

    logic [10:0] outVec;
    assign outVec = {en_f, en_d, en_e, en_m, en_w, clr_d, clr_e, clr_m, clr_w, redirect_go, fetch_drop};

    always #5 clk = ~clk;

    pipe_ctrl dut (
        .clk(clk), .rst(rst), .ibus_busy(ibus_busy), .ibus_done(ibus_done),
        .dbus_busy(dbus_busy), .mdu_busy(mdu_busy), .load_use(load_use), .redirect(redirect),
        .en_f(en_f), .en_d(en_d), .en_e(en_e), .en_m(en_m), .en_w(en_w),
        .clr_d(clr_d), .clr_e(clr_e), .clr_m(clr_m), .clr_w(clr_w),
        .redirect_go(redirect_go), .fetch_drop(fetch_drop), .stall_cycles(stall_cycles)
    );

    sat_counter #(.RST_VAL(32'hFFFF_FFFE)) satDut (
        .clk(clk), .rst(satRst), .inc(satInc), .count(satCount)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Stage k (F=0..W=4) is the stall point: earlier stages hold, stage k takes
    // a bubble, later stages flow. k=5 freezes everything.
    function automatic logic [10:0] expOut(input logic r, ib, id, db, md, lu, rd, pend, drop);
        int k;
        logic [4:0] en;
        logic [3:0] clr;
        logic fd;
        if (r) return 11'b11111_1111_00;
        fd = drop & id;
        if (db) k = 5;
        else if (md) k = 3;
        else if (rd | pend) return {5'b11111, 4'b1100, 1'b1, fd};
        else if (lu) k = 2;
        else if (drop | (ib & ~id)) k = 1;
        else k = 0;
        for (int i = 0; i < 5; i++) en[4 - i] = (i >= k);
        for (int i = 1; i < 5; i++) clr[4 - i] = (i == k);
        return {en, clr, 1'b0, fd};
    endfunction

    always @(negedge clk) begin
        if (checkEn) begin
            logic [10:0] e;
            e = expOut(rst, ibus_busy, ibus_done, dbus_busy, mdu_busy, load_use, redirect, mPend, mDrop);
            chk("outputs", 32'(outVec), 32'(e));
            chk("stall_cycles", stall_cycles, mCnt);
            if (rst) begin
                mPend = 1'b0;
                mDrop = 1'b0;
                mCnt  = 32'd0;
            end else begin
                if (!e[10] && mCnt != 32'hFFFF_FFFF) mCnt = mCnt + 32'd1;
                if (e[1]) mPend = 1'b0;
                else if (redirect && (dbus_busy || mdu_busy)) mPend = 1'b1;
                if (mDrop) begin
                    if (!e[1] && ibus_done) mDrop = 1'b0;
                end else if (e[1] && ibus_busy && !ibus_done) begin
                    mDrop = 1'b1;
                end
            end
        end
    end

    task automatic step(input logic r, ib, id, db, md, lu, rd);
        @(posedge clk);
        #1;
        rst = r; ibus_busy = ib; ibus_done = id; dbus_busy = db;
        mdu_busy = md; load_use = lu; redirect = rd;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; ibus_busy = 1'b0; ibus_done = 1'b0; dbus_busy = 1'b0;
        mdu_busy = 1'b0; load_use = 1'b0; redirect = 1'b0;
        satRst = 1'b1; satInc = 1'b0;
        checkEn = 1'b1;

        // reset held two cycles
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        chk("reset_outs", 32'(outVec), 32'(11'b11111_1111_00));
        step(0, 0, 0, 0, 0, 0, 0);
        chk("post_reset_outs", 32'(outVec), 32'(11'b11111_0000_00));
        chk("post_reset_cnt", stall_cycles, 32'd0);

        // dbus stall with a redirect buried in it
        step(0, 0, 0, 1, 0, 0, 0);
        chk("mem_stall1", 32'(outVec), 32'd0);
        step(0, 0, 0, 1, 0, 0, 1);
        chk("mem_stall2", 32'(outVec), 32'd0);
        step(0, 0, 0, 1, 0, 0, 0);
        chk("mem_stall3", 32'(outVec), 32'd0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("pend_applied", 32'(outVec), 32'(11'b11111_1100_10));
        step(0, 0, 0, 0, 0, 0, 0);
        chk("pend_once", 32'(outVec), 32'(11'b11111_0000_00));
        chk("mem_stall_cnt", stall_cycles, 32'd3);

        // mdu stall hides load_use until it releases
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 1, 1, 0);
            chk("exe_stall", 32'(outVec), 32'(11'b00011_0010_00));
        end
        step(0, 0, 0, 0, 0, 1, 0);
        chk("load_use_bubble", 32'(outVec), 32'(11'b00111_0100_00));
        step(0, 0, 0, 0, 0, 0, 0);
        chk("after_bubble", 32'(outVec), 32'(11'b11111_0000_00));

        // redirect with fetch in flight -> drop the stale response
        step(0, 1, 0, 0, 0, 0, 1);
        chk("redirect_inflight", 32'(outVec), 32'(11'b11111_1100_10));
        step(0, 1, 0, 0, 0, 0, 0);
        chk("drop_wait", 32'(outVec), 32'(11'b01111_1000_00));
        step(0, 0, 1, 0, 0, 0, 0);
        chk("drop_resp", 32'(outVec), 32'(11'b01111_1000_01));
        step(0, 0, 0, 0, 0, 0, 0);
        chk("back_to_run", 32'(outVec), 32'(11'b11111_0000_00));

        // redirect beats load_use
        step(0, 0, 0, 0, 0, 1, 1);
        chk("redir_vs_lu", 32'(outVec), 32'(11'b11111_1100_10));
        step(0, 0, 0, 0, 0, 0, 0);
        chk("no_extra_bubble", 32'(outVec), 32'(11'b11111_0000_00));

        // saturation on a counter preloaded near the top
        @(posedge clk); #1 satRst = 1'b0;
        @(negedge clk);
        chk("sat_preload", satCount, 32'hFFFF_FFFE);
        satInc = 1'b1;
        @(negedge clk);
        chk("sat_reach_max", satCount, 32'hFFFF_FFFF);
        for (int i = 0; i < 3; i++) @(negedge clk);
        chk("sat_hold", satCount, 32'hFFFF_FFFF);
        satInc = 1'b0;

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(63) == 0),
                 ($urandom_range(9) < 4), ($urandom_range(9) < 3),
                 ($urandom_range(9) < 2), ($urandom_range(19) < 3),
                 ($urandom_range(9) < 2), ($urandom_range(9) == 0));
        end

        step(0, 0, 0, 0, 0, 0, 0);
        checkEn = 1'b0;
        @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
